// File: rtl/cache_sa_wb_if.sv
// cache_sa_wb_if -- CPU-side and backing-memory-side signal bundle for cache_sa_wb.
//   CPU side    : addr, rmem, wmem, data_in -> cache; data_out, stall_me <- cache
//   flush       : flush_req -> cache; flush_done <- cache
//   memory side : mem_req, mem_we, mem_addr, mem_wdata <- cache; mem_rdata, mem_ack -> cache
// modport slave is the cache; modport master is the CPU plus backing memory.
interface cache_sa_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic              rmem;
  logic              wmem;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              stall_me;
  logic              flush_req;
  logic              flush_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output addr, rmem, wmem, data_in, flush_req, mem_rdata, mem_ack,
    input  data_out, stall_me, flush_done, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  addr, rmem, wmem, data_in, flush_req, mem_rdata, mem_ack,
    output data_out, stall_me, flush_done, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_sa_wb.sv
// cache_sa_wb -- 1- or 2-way set-associative, write-back, write-allocate cache
// with single-word backing-memory bursts and a whole-cache flush.
//   clock_me : sole clock, rising edge
//   reset_0  : synchronous active-low reset
//   bus      : cache_sa_wb_if.slave (CPU request/response, flush, memory beats)
//
// state | meaning
// IDLE  | serve hits; on miss pick victim; accept flush when CPU quiet
// WBACK | write 16 words of the dirty victim line to memory
// FILL  | read 16 words of the requested line from memory
// FLUSH | walk every set/way, write back and clean each dirty line
module cache_sa_wb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int OFFS_W  = 4,
  parameter int INDEX_W = 6,
  parameter int WAYS    = 2
) (
  input logic        clock_me,
  input logic        reset_0,
  cache_sa_wb_if.slave bus
);
  localparam int WORDS = 1 << OFFS_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFS_W - 2;
  localparam int WAY_W = 1;

  typedef enum logic [1:0] {IDLE, WBACK, FILL, FLUSH} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] data_mem [WAYS][SETS][WORDS];
  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [SETS-1:0]   valid    [WAYS];
  logic [SETS-1:0]   dirty    [WAYS];
  logic [SETS-1:0]   lru;

  logic [OFFS_W-1:0]  beat;
  logic [WAY_W-1:0]   vic_way;
  logic [INDEX_W-1:0] flush_idx;
  logic [WAY_W-1:0]   flush_way;
  logic               flush_done_q;

  logic [OFFS_W-1:0]  req_offs;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               req;

  assign req_offs  = bus.addr[OFFS_W+1:2];
  assign req_index = bus.addr[INDEX_W+OFFS_W+1:OFFS_W+2];
  assign req_tag   = bus.addr[ADDR_W-1:INDEX_W+OFFS_W+2];
  assign req       = bus.rmem | bus.wmem;

  logic [WAYS-1:0]  way_hit;
  logic [WAY_W-1:0] hit_way;
  logic             hit;

  always_comb begin
    way_hit = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w] = valid[w][req_index] && (tag_mem[w][req_index] == req_tag);
      if (way_hit[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit          = |way_hit;
  assign bus.data_out = data_mem[hit_way][req_index][req_offs];

  // Victim: first invalid way, else the way the LRU bit points at.
  logic [WAY_W-1:0] vic_sel;
  logic             vic_wb;

  always_comb begin
    vic_sel = '0;
    if (WAYS == 2) begin
      if (!valid[0][req_index])           vic_sel = 1'b0;
      else if (!valid[WAYS-1][req_index]) vic_sel = 1'b1;
      else                                vic_sel = lru[req_index];
    end
  end

  assign vic_wb = valid[vic_sel][req_index] & dirty[vic_sel][req_index];

  logic beat_last, fl_dirty, flush_last_line;

  assign beat_last       = (beat == '1);
  assign fl_dirty        = valid[flush_way][flush_idx] & dirty[flush_way][flush_idx];
  assign flush_last_line = (flush_idx == INDEX_W'(SETS-1)) && (flush_way == WAY_W'(WAYS-1));

  logic stall, mem_req, mem_we, line_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    line_done = 1'b0;
    case (state)
      IDLE: begin
        stall = req & ~hit;
        if (req && !hit)             state_nxt = vic_wb ? WBACK : FILL;
        else if (!req && bus.flush_req) state_nxt = FLUSH;
      end
      WBACK: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_mem[vic_way][req_index], req_index, beat, 2'b00};
        mem_wdata = data_mem[vic_way][req_index][beat];
        if (bus.mem_ack && beat_last) state_nxt = FILL;
      end
      FILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_index, beat, 2'b00};
        if (bus.mem_ack && beat_last) state_nxt = IDLE;
      end
      FLUSH: begin
        stall = req;
        if (fl_dirty) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {tag_mem[flush_way][flush_idx], flush_idx, beat, 2'b00};
          mem_wdata = data_mem[flush_way][flush_idx][beat];
          line_done = bus.mem_ack & beat_last;
        end else begin
          line_done = 1'b1;
        end
        if (line_done && flush_last_line) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset is synchronous, so the state register may still hold a burst
    // state during the reset cycle; keep the outputs quiet regardless.
    if (!reset_0) begin
      stall   = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  assign bus.stall_me   = stall;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.flush_done = flush_done_q & reset_0;

  logic hit_any, hit_wr, fill_beat;

  assign hit_any   = (state == IDLE) & req & hit;
  assign hit_wr    = (state == IDLE) & bus.wmem & hit;
  assign fill_beat = (state == FILL) & bus.mem_ack & reset_0;

  always_ff @(posedge clock_me) begin
    if (!reset_0) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock_me) begin
    if (!reset_0) begin
      for (int w = 0; w < WAYS; w++) begin
        valid[w] <= '0;
        dirty[w] <= '0;
      end
      lru          <= '0;
      beat         <= '0;
      vic_way      <= '0;
      flush_idx    <= '0;
      flush_way    <= '0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state)
        IDLE: begin
          beat      <= '0;
          flush_idx <= '0;
          flush_way <= '0;
          if (hit_wr) dirty[hit_way][req_index] <= 1'b1;
          if (hit_any && WAYS == 2) lru[req_index] <= ~hit_way;
          if (req && !hit) vic_way <= vic_sel;
        end
        WBACK: begin
          if (bus.mem_ack) beat <= beat + 1'b1;
        end
        FILL: begin
          if (bus.mem_ack) begin
            beat <= beat + 1'b1;
            if (beat_last) begin
              valid[vic_way][req_index] <= 1'b1;
              dirty[vic_way][req_index] <= 1'b0;
              if (WAYS == 2) lru[req_index] <= ~vic_way;
            end
          end
        end
        FLUSH: begin
          if (fl_dirty && bus.mem_ack) beat <= beat + 1'b1;
          if (line_done) begin
            if (fl_dirty) dirty[flush_way][flush_idx] <= 1'b0;
            if (flush_way == WAY_W'(WAYS-1)) begin
              flush_way <= '0;
              flush_idx <= flush_idx + 1'b1;
            end else begin
              flush_way <= flush_way + 1'b1;
            end
            if (flush_last_line) flush_done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clock_me) begin
    if (hit_wr)         data_mem[hit_way][req_index][req_offs] <= bus.data_in;
    else if (fill_beat) data_mem[vic_way][req_index][beat]     <= bus.mem_rdata;
    if (fill_beat && beat_last) tag_mem[vic_way][req_index] <= req_tag;
  end
endmodule

// File: tb/tb_cache_sa_wb.sv
// tb_cache_sa_wb -- directed bench for cache_sa_wb (2-way, 64 sets, 16-word lines).
// Backing memory model answers each beat with an optional random 0-5 cycle delay,
// logs every accepted beat, and checks beat stability while ack is withheld.
module tb_cache_sa_wb;
  logic clock_me = 1'b0;
  logic reset_0  = 1'b0;

  always #5 clock_me = ~clock_me;

  cache_sa_wb_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  cache_sa_wb #(
    .DATA_W(32), .ADDR_W(32), .OFFS_W(4), .INDEX_W(6), .WAYS(2)
  ) dut (
    .clock_me(clock_me),
    .reset_0 (reset_0),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [31:0] d;
  } beat_t;

  logic [31:0] mem_model [0:4095];
  beat_t       beats [$];
  int          n_checks = 0;
  int          n_err    = 0;
  bit          rand_dly = 1'b0;
  int          dly_left = 0;
  bit          pend     = 1'b0;
  logic [31:0] pend_a, pend_d;
  logic        pend_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Backing memory: decide ack on the falling edge so the beat it records is
  // exactly what the cache presents at the following rising edge.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clock_me);
      if (!reset_0) begin
        bus.mem_ack = 1'b0;
        dly_left    = 0;
        pend        = 1'b0;
      end else if (bus.mem_req) begin
        if (pend) begin
          chk("beat_hold_addr", bus.mem_addr, pend_a);
          chk("beat_hold_we", 32'(bus.mem_we), 32'(pend_we));
          chk("beat_hold_wdata", bus.mem_wdata, pend_d);
        end
        if (dly_left == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_model[bus.mem_addr[13:2]];
          if (bus.mem_we) mem_model[bus.mem_addr[13:2]] = bus.mem_wdata;
          beats.push_back('{a: bus.mem_addr, we: bus.mem_we, d: bus.mem_wdata});
          pend     = 1'b0;
          dly_left = rand_dly ? int'($urandom_range(0, 5)) : 0;
        end else begin
          bus.mem_ack = 1'b0;
          dly_left--;
          pend    = 1'b1;
          pend_a  = bus.mem_addr;
          pend_we = bus.mem_we;
          pend_d  = bus.mem_wdata;
        end
      end else begin
        if (pend) chk("beat_req_dropped", 32'(bus.mem_req), 32'd1);
        bus.mem_ack = 1'b0;
        pend        = 1'b0;
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d);
    @(negedge clock_me);
    bus.addr    = a;
    bus.rmem    = r;
    bus.wmem    = w;
    bus.data_in = d;
    #1;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock_me);
      #1;
      if (bus.stall_me === 1'b0) break;
    end
    chk(tag, 32'(bus.stall_me), 32'd0);
  endtask

  task automatic chk_burst(input string tag, input int start, input logic [31:0] base, input logic we);
    for (int k = 0; k < 16; k++) begin
      if (start + k < beats.size()) begin
        chk({tag, "_addr"}, beats[start+k].a, base + 32'(4*k));
        chk({tag, "_we"}, 32'(beats[start+k].we), 32'(we));
      end
    end
  endtask

  task automatic do_flush(input string tag, input int exp_beats);
    int pulses;
    pulses = 0;
    beats.delete();
    @(negedge clock_me);
    bus.flush_req = 1'b1;
    @(negedge clock_me);
    bus.flush_req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock_me);
      #1;
      if (bus.flush_done === 1'b1) pulses++;
    end
    chk({tag, "_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_beats"}, 32'(beats.size()), 32'(exp_beats));
  endtask

  initial begin
    logic [31:0] exp_d;
    bus.addr = '0; bus.rmem = 1'b0; bus.wmem = 1'b0; bus.data_in = '0; bus.flush_req = 1'b0;
    for (int i = 0; i < 4096; i++) mem_model[i] = 32'hA000_0000 | 32'(i * 4);

    // Reset with a pending read: everything must stay quiet.
    reset_0  = 1'b0;
    bus.addr = 32'h100;
    bus.rmem = 1'b1;
    repeat (2) @(negedge clock_me);
    #1;
    chk("rst_stall", 32'(bus.stall_me), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_flush_done", 32'(bus.flush_done), 32'd0);
    @(negedge clock_me);
    bus.rmem = 1'b0;
    reset_0  = 1'b1;
    #1;
    chk("post_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("post_rst_stall", 32'(bus.stall_me), 32'd0);

    // Cold read miss at 0x100.
    beats.delete();
    drive(32'h100, 1'b1, 1'b0, '0);
    chk("rd_miss_stall", 32'(bus.stall_me), 32'd1);
    wait_ready("rd_fill_done", 100);
    chk("rd_fill_beats", 32'(beats.size()), 32'd16);
    chk_burst("rd_fill", 0, 32'h100, 1'b0);
    chk("rd_data_100", bus.data_out, 32'hA000_0100);
    drive(32'h13C, 1'b1, 1'b0, '0);
    chk("rd_hit_stall", 32'(bus.stall_me), 32'd0);
    chk("rd_data_13c", bus.data_out, 32'hA000_013C);

    // Write hit then read back.
    drive(32'h104, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("wr_hit_stall", 32'(bus.stall_me), 32'd0);
    drive(32'h104, 1'b1, 1'b0, '0);
    chk("wr_rd_stall", 32'(bus.stall_me), 32'd0);
    chk("wr_rd_data", bus.data_out, 32'hDEAD_BEEF);
    chk("wr_hit_no_beats", 32'(beats.size()), 32'd16);

    // Conflict misses in set 4 with random ack delays.
    rand_dly = 1'b1;
    beats.delete();
    drive(32'h1100, 1'b1, 1'b0, '0);
    chk("miss_1100_stall", 32'(bus.stall_me), 32'd1);
    wait_ready("fill_1100_done", 400);
    chk("fill_1100_beats", 32'(beats.size()), 32'd16);
    chk_burst("fill_1100", 0, 32'h1100, 1'b0);
    chk("rd_data_1100", bus.data_out, 32'hA000_1100);

    beats.delete();
    drive(32'h2100, 1'b1, 1'b0, '0);
    chk("miss_2100_stall", 32'(bus.stall_me), 32'd1);
    wait_ready("evict_done", 800);
    chk("evict_beats", 32'(beats.size()), 32'd32);
    chk_burst("evict_wb", 0, 32'h100, 1'b1);
    for (int k = 0; k < 16; k++) begin
      exp_d = (k == 1) ? 32'hDEAD_BEEF : 32'hA000_0100 + 32'(4*k);
      if (k < beats.size()) chk("evict_wb_data", beats[k].d, exp_d);
    end
    chk_burst("evict_fill", 16, 32'h2100, 1'b0);
    chk("rd_data_2100", bus.data_out, 32'hA000_2100);

    // Re-read the evicted line: must come back from memory with the written word.
    beats.delete();
    drive(32'h104, 1'b1, 1'b0, '0);
    chk("miss_104_stall", 32'(bus.stall_me), 32'd1);
    wait_ready("refill_104_done", 400);
    chk("refill_104_beats", 32'(beats.size()), 32'd16);
    chk_burst("refill_104", 0, 32'h100, 1'b0);
    chk("rd_data_104", bus.data_out, 32'hDEAD_BEEF);

    // Two dirty lines, then flush twice.
    rand_dly = 1'b0;
    drive(32'h2108, 1'b0, 1'b1, 32'h1111_2222);
    chk("wr_2108_stall", 32'(bus.stall_me), 32'd0);
    drive(32'h104, 1'b0, 1'b1, 32'h3333_4444);
    chk("wr_104_stall", 32'(bus.stall_me), 32'd0);
    drive(32'h0, 1'b0, 1'b0, '0);
    do_flush("flush1", 32);
    chk_burst("flush1_l0", 0, 32'h2100, 1'b1);
    chk_burst("flush1_l1", 16, 32'h100, 1'b1);
    for (int k = 0; k < 32; k++) begin
      if (k < 16) exp_d = (k == 2) ? 32'h1111_2222 : 32'hA000_2100 + 32'(4*k);
      else        exp_d = (k == 17) ? 32'h3333_4444 : 32'hA000_0100 + 32'(4*(k-16));
      if (k < beats.size()) chk("flush1_data", beats[k].d, exp_d);
    end
    do_flush("flush2", 0);
    drive(32'h104, 1'b1, 1'b0, '0);
    chk("post_flush_hit_stall", 32'(bus.stall_me), 32'd0);
    chk("post_flush_data", bus.data_out, 32'h3333_4444);

    // Reset in the middle of a fill, at beat 7.
    beats.delete();
    drive(32'h3100, 1'b1, 1'b0, '0);
    for (int i = 0; i < 200; i++) begin
      if (beats.size() >= 8) break;
      @(negedge clock_me);
    end
    chk("mid_fill_reached", 32'(beats.size() >= 8), 32'd1);
    chk("mid_fill_beat7", beats[7].a, 32'h311C);
    reset_0 = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(bus.stall_me), 32'd0);
    @(negedge clock_me);
    #1;
    chk("mid_rst_next_mem_req", 32'(bus.mem_req), 32'd0);
    chk("mid_rst_next_stall", 32'(bus.stall_me), 32'd0);
    reset_0 = 1'b1;
    #1;
    chk("after_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("after_rst_miss", 32'(bus.stall_me), 32'd1);
    beats.delete();
    wait_ready("refill_3100_done", 100);
    chk("refill_3100_beats", 32'(beats.size()), 32'd16);
    chk_burst("refill_3100", 0, 32'h3100, 1'b0);
    chk("rd_data_3100", bus.data_out, 32'hA000_3100);

    beats.delete();
    drive(32'h104, 1'b1, 1'b0, '0);
    chk("after_rst_104_miss", 32'(bus.stall_me), 32'd1);
    wait_ready("after_rst_104_done", 100);
    chk("after_rst_104_beats", 32'(beats.size()), 32'd16);
    chk("after_rst_104_data", bus.data_out, 32'h3333_4444);

    drive(32'h0, 1'b0, 1'b0, '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
